// File: rtl/memaccess.sv
// memaccess -- data-memory pipeline stage between execute and writeback.
//
// Takes one operation at a time from EX over a valid/stall handshake.
// It runs loads and stores against an external synchronous single-port
// RAM that has one cycle of read latency, and presents a registered
// result to WB over the same handshake. Pass operations (op 00 and 11)
// and stores reach the output one cycle after they are accepted. Loads
// take two cycles: one bubble while the RAM read is in flight, then the
// captured read data.
//
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   v_i, stall_o     EX side handshake (operation valid / hold request to EX)
//   op_i             00 pass, 01 load, 10 store, 11 pass
//   addr_i           word address for load/store
//   data_i           ALU result (pass) or store data
//   wb_i, rd_num_i   register write enable and destination register
//   v_o, stall_i     WB side handshake (output valid / hold request from WB)
//   wb_o, rd_num_o   registered write enable and destination register
//   data_o           registered result
//   mem_addr_o       RAM address (combinational, always addr_i)
//   mem_we_o         RAM write enable (combinational)
//   mem_d_o          RAM write data (combinational, always data_i)
//   mem_q_i          RAM read data, valid one cycle after the address edge
module memaccess #(
  parameter int WORD = 32,
  parameter int ADDR = 16,
  parameter int W_RD = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  output logic            stall_o,
  input  logic [1:0]      op_i,
  input  logic [ADDR-1:0] addr_i,
  input  logic [WORD-1:0] data_i,
  input  logic            wb_i,
  input  logic [W_RD-1:0] rd_num_i,
  output logic            v_o,
  input  logic            stall_i,
  output logic            wb_o,
  output logic [W_RD-1:0] rd_num_o,
  output logic [WORD-1:0] data_o,
  output logic [ADDR-1:0] mem_addr_o,
  output logic            mem_we_o,
  output logic [WORD-1:0] mem_d_o,
  input  logic [WORD-1:0] mem_q_i
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic            v_reg, v_next;
  logic            wb_reg, wb_next;
  logic [W_RD-1:0] rd_reg, rd_next;
  logic [WORD-1:0] data_reg, data_next;
  // Destination fields of an in-flight load. They are held here while
  // the RAM read completes.
  logic            lwb_reg, lwb_next;
  logic [W_RD-1:0] lrd_reg, lrd_next;

  logic hold;
  logic accept;

  // The output register is full and WB will not take it.
  assign hold   = v_reg & stall_i;
  assign accept = rst & (state_reg == IDLE) & v_i & ~hold;

  // During LOAD, v_reg is 0, so hold cannot be asserted. The stall toward
  // EX in LOAD only blocks a new accept while the read is in flight.
  assign stall_o = ~rst | (state_reg == LOAD) | hold;

  assign mem_addr_o = addr_i;
  assign mem_d_o    = data_i;
  assign mem_we_o   = accept & (op_i == OP_STORE);

  assign v_o      = v_reg;
  assign wb_o     = wb_reg;
  assign rd_num_o = rd_reg;
  assign data_o   = data_reg;

  always_comb begin
    state_next = state_reg;
    v_next     = v_reg;
    wb_next    = wb_reg;
    rd_next    = rd_reg;
    data_next  = data_reg;
    lwb_next   = lwb_reg;
    lrd_next   = lrd_reg;

    if (!hold) begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (op_i == OP_LOAD) begin
              // The RAM samples addr_i at this edge. Emit a bubble now
              // and capture mem_q_i on the next edge.
              lwb_next   = wb_i;
              lrd_next   = rd_num_i;
              v_next     = 1'b0;
              state_next = LOAD;
            end else if (op_i == OP_STORE) begin
              v_next    = 1'b1;
              wb_next   = 1'b0;
              rd_next   = rd_num_i;
              data_next = data_i;
            end else begin
              v_next    = 1'b1;
              wb_next   = wb_i;
              rd_next   = rd_num_i;
              data_next = data_i;
            end
          end else begin
            v_next = 1'b0;
          end
        end
        LOAD: begin
          v_next     = 1'b1;
          wb_next    = lwb_reg;
          rd_next    = lrd_reg;
          data_next  = mem_q_i;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // Also discards any load in flight, so no late v_o pulse appears.
      state_reg <= IDLE;
      v_reg     <= 1'b0;
      wb_reg    <= 1'b0;
      rd_reg    <= '0;
      data_reg  <= '0;
      lwb_reg   <= 1'b0;
      lrd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      v_reg     <= v_next;
      wb_reg    <= wb_next;
      rd_reg    <= rd_next;
      data_reg  <= data_next;
      lwb_reg   <= lwb_next;
      lrd_reg   <= lrd_next;
    end
  end

endmodule

// File: tb/tb_memaccess.sv
// tb_memaccess -- directed bench for memaccess with a behavioural
// synchronous single-port RAM attached to the memory port.
module tb_memaccess;

  localparam int WORD = 32;
  localparam int ADDR = 16;
  localparam int W_RD = 5;

  logic            clk;
  logic            rst;
  logic            v_i;
  logic            stall_o;
  logic [1:0]      op_i;
  logic [ADDR-1:0] addr_i;
  logic [WORD-1:0] data_i;
  logic            wb_i;
  logic [W_RD-1:0] rd_num_i;
  logic            v_o;
  logic            stall_i;
  logic            wb_o;
  logic [W_RD-1:0] rd_num_o;
  logic [WORD-1:0] data_o;
  logic [ADDR-1:0] mem_addr_o;
  logic            mem_we_o;
  logic [WORD-1:0] mem_d_o;
  logic [WORD-1:0] mem_q_i;

  int checks;
  int passed;

  logic [WORD-1:0] ram [0:(1<<ADDR)-1];

  memaccess #(.WORD(WORD), .ADDR(ADDR), .W_RD(W_RD)) dut (
    .clk       (clk),
    .rst       (rst),
    .v_i       (v_i),
    .stall_o   (stall_o),
    .op_i      (op_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .wb_i      (wb_i),
    .rd_num_i  (rd_num_i),
    .v_o       (v_o),
    .stall_i   (stall_i),
    .wb_o      (wb_o),
    .rd_num_o  (rd_num_o),
    .data_o    (data_o),
    .mem_addr_o(mem_addr_o),
    .mem_we_o  (mem_we_o),
    .mem_d_o   (mem_d_o),
    .mem_q_i   (mem_q_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-before-write single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_d_o;
    mem_q_i <= ram[mem_addr_o];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [ADDR-1:0] a,
                       input logic [WORD-1:0] d, input logic wb, input logic [W_RD-1:0] rd);
    v_i = v; op_i = op; addr_i = a; data_i = d; wb_i = wb; rd_num_i = rd;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    stall_i = 1'b0;
    rst = 1'b0;
    // Store pending during reset.
    drive(1'b1, 2'b10, 16'h0020, 32'h0000_AAAA, 1'b0, 5'd1);

    // ---- reset ----
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_v_o", v_o, 1'b0);
      chk("rst_wb_o", wb_o, 1'b0);
      chk("rst_rd_num_o", rd_num_o, 5'd0);
      chk("rst_data_o", data_o, 32'h0);
      chk("rst_stall_o", stall_o, 1'b1);
      chk("rst_mem_we_o", mem_we_o, 1'b0);
    end
    rst = 1'b1;
    #1;
    chk("rel_stall_o", stall_o, 1'b0);
    chk("rel_mem_we_o", mem_we_o, 1'b1);
    tick();
    chk("rel_store_v_o", v_o, 1'b1);
    chk("rel_store_wb_o", wb_o, 1'b0);
    chk("rel_store_data_o", data_o, 32'h0000_AAAA);
    chk("rel_store_rd_o", rd_num_o, 5'd1);

    // ---- pass-through stream (last op uses encoding 11) ----
    drive(1'b1, 2'b00, 16'h0000, 32'd1, 1'b1, 5'd5);
    #1;
    chk("pass1_stall_o", stall_o, 1'b0);
    chk("pass1_we", mem_we_o, 1'b0);
    tick();
    chk("pass1_v_o", v_o, 1'b1);
    chk("pass1_data_o", data_o, 32'd1);
    chk("pass1_rd_o", rd_num_o, 5'd5);
    chk("pass1_wb_o", wb_o, 1'b1);
    drive(1'b1, 2'b00, 16'h0000, 32'd2, 1'b1, 5'd6);
    #1;
    chk("pass2_stall_o", stall_o, 1'b0);
    tick();
    chk("pass2_v_o", v_o, 1'b1);
    chk("pass2_data_o", data_o, 32'd2);
    chk("pass2_rd_o", rd_num_o, 5'd6);
    drive(1'b1, 2'b00, 16'h0000, 32'd3, 1'b0, 5'd7);
    #1;
    chk("pass3_stall_o", stall_o, 1'b0);
    tick();
    chk("pass3_v_o", v_o, 1'b1);
    chk("pass3_data_o", data_o, 32'd3);
    chk("pass3_wb_o", wb_o, 1'b0);
    drive(1'b1, 2'b11, 16'h0000, 32'd4, 1'b1, 5'd8);
    #1;
    chk("pass4_stall_o", stall_o, 1'b0);
    chk("pass4_we", mem_we_o, 1'b0);
    tick();
    chk("pass4_v_o", v_o, 1'b1);
    chk("pass4_data_o", data_o, 32'd4);
    chk("pass4_rd_o", rd_num_o, 5'd8);
    chk("pass4_wb_o", wb_o, 1'b1);

    // ---- store then load same address ----
    drive(1'b1, 2'b10, 16'h0010, 32'hDEAD_BEEF, 1'b1, 5'd0);
    #1;
    chk("st_we", mem_we_o, 1'b1);
    chk("st_stall_o", stall_o, 1'b0);
    tick();
    chk("st_v_o", v_o, 1'b1);
    chk("st_wb_o", wb_o, 1'b0);
    drive(1'b1, 2'b01, 16'h0010, 32'h0, 1'b1, 5'd3);
    #1;
    chk("ld_accept_we", mem_we_o, 1'b0);
    chk("ld_accept_stall_o", stall_o, 1'b0);
    tick();
    v_i = 1'b0;
    #1;
    chk("ld_bubble_v_o", v_o, 1'b0);
    chk("ld_bubble_stall_o", stall_o, 1'b1);
    chk("ld_bubble_we", mem_we_o, 1'b0);
    tick();
    chk("ld_v_o", v_o, 1'b1);
    chk("ld_data_o", data_o, 32'hDEAD_BEEF);
    chk("ld_rd_o", rd_num_o, 5'd3);
    chk("ld_wb_o", wb_o, 1'b1);
    chk("ld_done_stall_o", stall_o, 1'b0);

    // ---- WB backpressure ----
    drive(1'b1, 2'b00, 16'h0000, 32'h55, 1'b1, 5'd10);
    tick();
    chk("bp_pre_data_o", data_o, 32'h55);
    drive(1'b1, 2'b00, 16'h0000, 32'h66, 1'b1, 5'd11);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall_o", stall_o, 1'b1);
      chk("bp_we", mem_we_o, 1'b0);
      tick();
      chk("bp_hold_data_o", data_o, 32'h55);
      chk("bp_hold_v_o", v_o, 1'b1);
      chk("bp_hold_rd_o", rd_num_o, 5'd10);
    end
    stall_i = 1'b0;
    #1;
    chk("bp_rel_stall_o", stall_o, 1'b0);
    tick();
    chk("bp_rel_data_o", data_o, 32'h66);
    chk("bp_rel_rd_o", rd_num_o, 5'd11);
    v_i = 1'b0;
    tick();
    chk("bp_idle_v_o", v_o, 1'b0);

    // ---- reset during LOAD ----
    drive(1'b1, 2'b01, 16'h0010, 32'h0, 1'b1, 5'd7);
    tick();
    v_i = 1'b0;
    #1;
    chk("rml_stall_o", stall_o, 1'b1);
    rst = 1'b0;
    tick();
    chk("rml_v_o", v_o, 1'b0);
    chk("rml_stall_rst", stall_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("rml_rel_stall_o", stall_o, 1'b0);
    tick();
    chk("rml_after_v_o", v_o, 1'b0);
    chk("rml_after_data_o", data_o, 32'h0);
    chk("rml_after_rd_o", rd_num_o, 5'd0);
    tick();
    chk("rml_after2_v_o", v_o, 1'b0);

    // ---- address wrap ----
    drive(1'b1, 2'b10, 16'hFFFF, 32'h1234, 1'b0, 5'd0);
    #1;
    chk("wr_st_addr", mem_addr_o, 16'hFFFF);
    chk("wr_st_we", mem_we_o, 1'b1);
    chk("wr_st_d", mem_d_o, 32'h1234);
    tick();
    drive(1'b1, 2'b01, 16'hFFFF, 32'h0, 1'b1, 5'd9);
    #1;
    chk("wr_ld_addr", mem_addr_o, 16'hFFFF);
    tick();
    v_i = 1'b0;
    tick();
    chk("wr_ld_v_o", v_o, 1'b1);
    chk("wr_ld_data_o", data_o, 32'h1234);
    chk("wr_ld_rd_o", rd_num_o, 5'd9);

    // ---- store accepted right after reset release reached RAM ----
    drive(1'b1, 2'b01, 16'h0020, 32'h0, 1'b1, 5'd2);
    tick();
    v_i = 1'b0;
    tick();
    chk("rst_store_ld_data_o", data_o, 32'h0000_AAAA);
    chk("rst_store_ld_rd_o", rd_num_o, 5'd2);
    tick();
    chk("final_v_o", v_o, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
